sargantana_icache_refill_buffer: RTL

//  Miss-refill stage directly upstream of the icache tag/data compare stage.
//  - Latches a miss, issues one line request to L2 and collects the response beats into a 256-bit line buffer.
//  - Presents the completed line as fill data plus array write controls (tag, index, victim way).
//  - That line then becomes the ifill data consumed by the compare stage on the replayed fetch.

---
 rtl/sargantana_icache_refill_buffer.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/sargantana_icache_refill_buffer.sv
// Icache miss-refill buffer: latches a miss, issues one line request to L2,
// assembles the response beats into a line and presents it for the array write.
// Optional critical-beat bypass is enabled by defining ICACHE_REFILL_BYPASS_EN.
module sargantana_icache_refill_buffer #(
   parameter int unsigned LINE_W = 256,
   parameter int unsigned BEAT_W = 64,
   parameter int unsigned TAG_W  = 20,
   parameter int unsigned IDX_W  = 6,
   parameter int unsigned N_WAY  = 4,
   localparam int unsigned N_BEATS = LINE_W / BEAT_W,
   localparam int unsigned CNT_W   = (N_BEATS > 1) ? $clog2(N_BEATS) : 1
) (
   input  logic                   clk_i,
   input  logic                   rstn_i,
   input  logic                   miss_i,
   input  logic [TAG_W-1:0]       miss_tag_i,
   input  logic [IDX_W-1:0]       miss_idx_i,
   input  logic [N_WAY-1:0]       miss_way_i,
   input  logic                   flush_i,
   output logic                   req_valid_o,
   input  logic                   req_ready_i,
   output logic [TAG_W+IDX_W-1:0] req_addr_o,
   input  logic                   rsp_valid_i,
   input  logic [BEAT_W-1:0]      rsp_data_i,
   input  logic                   rsp_error_i,
`ifdef ICACHE_REFILL_BYPASS_EN
   input  logic [CNT_W-1:0]       bypass_chunk_i,
   output logic                   bypass_valid_o,
   output logic [BEAT_W-1:0]      bypass_data_o,
`endif
   output logic                   fill_valid_o,
   input  logic                   fill_ack_i,
   output logic [LINE_W-1:0]      fill_data_o,
   output logic [TAG_W-1:0]       fill_tag_o,
   output logic [IDX_W-1:0]       fill_idx_o,
   output logic [N_WAY-1:0]       fill_way_o,
   output logic                   busy_o,
   output logic                   error_o
);

   localparam logic [CNT_W-1:0] LastBeat = CNT_W'(N_BEATS - 1);

   typedef enum logic [2:0] {StIdle, StReq, StRecv, StFill, StDrain} state_e;

   state_e              state_q, state_d;
   logic [TAG_W-1:0]    tag_q, tag_d;
   logic [IDX_W-1:0]    idx_q, idx_d;
   logic [N_WAY-1:0]    way_q, way_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [LINE_W-1:0]   buf_q, buf_d;
   logic                err_q, err_d;
   logic                error_q, error_d;
`ifdef ICACHE_REFILL_BYPASS_EN
   logic [CNT_W-1:0]    chunk_q, chunk_d;
   logic                byp_valid_q, byp_valid_d;
   logic [BEAT_W-1:0]   byp_data_q, byp_data_d;
`endif

   // Next-state logic for the refill FSM, beat counter and line buffer.
   always_comb begin
      state_d = state_q;
      tag_d   = tag_q;
      idx_d   = idx_q;
      way_d   = way_q;
      cnt_d   = cnt_q;
      buf_d   = buf_q;
      err_d   = err_q;
      error_d = 1'b0;
`ifdef ICACHE_REFILL_BYPASS_EN
      chunk_d     = chunk_q;
      byp_valid_d = 1'b0;
      byp_data_d  = byp_data_q;
`endif
      unique case (state_q)
         StIdle: begin
            if (miss_i) begin
               tag_d   = miss_tag_i;
               idx_d   = miss_idx_i;
               way_d   = miss_way_i;
               cnt_d   = '0;
               err_d   = 1'b0;
`ifdef ICACHE_REFILL_BYPASS_EN
               chunk_d = bypass_chunk_i;
`endif
               state_d = StReq;
            end
         end
         StReq: begin
            if (flush_i) begin
               // An accepted request still returns beats; they must be drained.
               state_d = req_ready_i ? StDrain : StIdle;
            end else if (req_ready_i) begin
               state_d = StRecv;
            end
         end
         StRecv: begin
            if (flush_i) begin
               // A beat in the flush cycle is counted but not stored.
               if (rsp_valid_i) begin
                  cnt_d   = (cnt_q == LastBeat) ? '0 : cnt_q + CNT_W'(1);
                  state_d = (cnt_q == LastBeat) ? StIdle : StDrain;
               end else begin
                  state_d = StDrain;
               end
            end else if (rsp_valid_i) begin
               buf_d[cnt_q*BEAT_W +: BEAT_W] = rsp_data_i;
               err_d = err_q | rsp_error_i;
`ifdef ICACHE_REFILL_BYPASS_EN
               if (cnt_q == chunk_q && !rsp_error_i) begin
                  byp_valid_d = 1'b1;
                  byp_data_d  = rsp_data_i;
               end
`endif
               if (cnt_q == LastBeat) begin
                  cnt_d = '0;
                  if (err_q || rsp_error_i) begin
                     error_d = 1'b1;
                     state_d = StIdle;
                  end else begin
                     state_d = StFill;
                  end
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
         end
         StFill: begin
            // Flush wins over an ack in the same cycle; either way the line leaves.
            if (flush_i || fill_ack_i) begin
               state_d = StIdle;
            end
         end
         StDrain: begin
            if (rsp_valid_i) begin
               if (cnt_q == LastBeat) begin
                  cnt_d   = '0;
                  state_d = StIdle;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // State and datapath registers with asynchronous reset.
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         state_q <= StIdle;
         tag_q   <= '0;
         idx_q   <= '0;
         way_q   <= '0;
         cnt_q   <= '0;
         buf_q   <= '0;
         err_q   <= 1'b0;
         error_q <= 1'b0;
`ifdef ICACHE_REFILL_BYPASS_EN
         chunk_q     <= '0;
         byp_valid_q <= 1'b0;
         byp_data_q  <= '0;
`endif
      end else begin
         state_q <= state_d;
         tag_q   <= tag_d;
         idx_q   <= idx_d;
         way_q   <= way_d;
         cnt_q   <= cnt_d;
         buf_q   <= buf_d;
         err_q   <= err_d;
         error_q <= error_d;
`ifdef ICACHE_REFILL_BYPASS_EN
         chunk_q     <= chunk_d;
         byp_valid_q <= byp_valid_d;
         byp_data_q  <= byp_data_d;
`endif
      end
   end

   assign req_valid_o  = (state_q == StReq);
   assign req_addr_o   = {tag_q, idx_q};
   assign fill_valid_o = (state_q == StFill);
   assign fill_data_o  = buf_q;
   assign fill_tag_o   = tag_q;
   assign fill_idx_o   = idx_q;
   assign fill_way_o   = way_q;
   assign busy_o       = (state_q != StIdle);
   assign error_o      = error_q;
`ifdef ICACHE_REFILL_BYPASS_EN
   assign bypass_valid_o = byp_valid_q;
   assign bypass_data_o  = byp_data_q;
`endif

`ifndef SYNTHESIS
   // L2 must not return beats before the request has been accepted.
   a_no_beat_in_req: assert property (@(posedge clk_i) disable iff (!rstn_i)
      !(state_q == StReq && rsp_valid_i));
`endif

endmodule
